// File: rtl/conv3x3_stream_layer.sv
// 3x3 zero-padded streaming convolution with banked runtime weights, bias and optional ReLU.
// Latency: 3 unstalled cycles from window completion to out_valid; one result per cycle sustained.
// Backpressure: out_valid && !out_ready freezes window, pipeline and output; in_ready drops meanwhile.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-low reset
//   start, ksel, relu_en   frame start pulse (IDLE only) with kernel bank / ReLU latched on it
//   w_we, w_addr, w_data   coefficient write in IDLE; addr = bank*10 + tap, tap 9 is the bias
//   in_valid/ready/data    raster-order pixel stream
//   out_valid/ready/data   raster-order result stream, out_last marks the final result
//   busy, done             not-IDLE flag; one-cycle pulse after the out_last handshake
module conv3x3_stream_layer #(
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int NUM_K = 2,
  parameter int KW    = (NUM_K > 1) ? $clog2(NUM_K) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [KW-1:0]               ksel,
  input  logic                        relu_en,
  input  logic                        w_we,
  input  logic [$clog2(NUM_K*10)-1:0] w_addr,
  input  logic [DW-1:0]               w_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int AW   = $clog2(NUM_K*10);
  localparam int NPIX = IMG_H*IMG_W;
  localparam int NTOT = NPIX + IMG_W + 1;   // real pixels plus injected flush zeros
  localparam int NW   = $clog2(NTOT + 1);
  localparam int SRN  = 2*IMG_W + 3;        // two lines plus three pixels cover a full window
  localparam int PW   = 2*DW;
  localparam int SW   = 2*DW + 4;
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [NW-1:0]        n;          // index of the next pixel entering the window
  logic [RW-1:0]        cr;         // centre row of the next window produced
  logic [CW-1:0]        cc;         // centre column of the next window produced
  logic [KW-1:0]        ksel_q;
  logic                 relu_q;
  logic [DW-1:0]        wram [NUM_K*10];
  logic [DW-1:0]        sr [SRN];   // sr[0] is the newest pixel
  logic                 stall, adv, produce;
  logic [DW-1:0]        pix;
  logic                 w_vld, w_last, m_top, m_bot, m_lft, m_rgt;
  logic signed [PW-1:0] win [9];
  logic signed [PW-1:0] wv [9];
  logic signed [PW-1:0] p1 [9];
  logic signed [SW-1:0] b1, acc, s2_acc, sh, sat;
  logic                 s1_vld, s1_last, s2_vld, s2_last;
  logic [AW-1:0]        wbase;
  logic [DW-1:0]        res;

  assign stall   = out_valid && !out_ready;
  assign produce = adv && (n >= NW'(IMG_W + 1));
  assign wbase   = AW'(ksel_q) * AW'(10);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    adv       = 1'b0;
    pix       = in_data;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        in_ready = !stall;
        adv      = in_valid && !stall;
        if (adv && n == NW'(IMG_W + 1)) state_nxt = RUN;
      end
      RUN: begin
        in_ready = !stall;
        adv      = in_valid && !stall;
        if (adv && n == NW'(NPIX - 1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        // Zero pixels push the last IMG_W+1 windows out; they also form the bottom padding.
        pix = '0;
        adv = !stall && (n < NW'(NTOT));
        if (out_valid && out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window tap (dr,dc) of the centre at pixel index n-IMG_W-1 sits IMG_W+1-dr*IMG_W-dc
  // places behind the newest pixel. Taps beyond an image edge are masked, which also
  // kills the row-wrap neighbours at columns 0 and IMG_W-1.
  for (genvar t = 0; t < 9; t++) begin : g_tap
    localparam int K   = IMG_W + 1 - (t/3 - 1)*IMG_W - (t%3 - 1);
    localparam bit TOP = (t/3 == 0);
    localparam bit BOT = (t/3 == 2);
    localparam bit LFT = (t%3 == 0);
    localparam bit RGT = (t%3 == 2);
    logic msk;
    assign msk    = (TOP && m_top) || (BOT && m_bot) || (LFT && m_lft) || (RGT && m_rgt);
    assign win[t] = msk ? '0 : PW'($signed(sr[K]));
    assign wv[t]  = PW'($signed(wram[wbase + AW'(t)]));
  end

  always_comb begin
    acc = (b1 <<< FRAC) + (SW'(1) <<< (FRAC - 1));
    for (int t = 0; t < 9; t++) acc = acc + SW'(p1[t]);
  end

  always_comb begin
    sh = s2_acc >>> FRAC;
    if (sh > SMAX)      sat = SMAX;
    else if (sh < SMIN) sat = SMIN;
    else                sat = sh;
    res = sat[DW-1:0];
    if (relu_q && res[DW-1]) res = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      n         <= '0;
      cr        <= '0;
      cc        <= '0;
      ksel_q    <= '0;
      relu_q    <= 1'b0;
      w_vld     <= 1'b0;
      w_last    <= 1'b0;
      m_top     <= 1'b0;
      m_bot     <= 1'b0;
      m_lft     <= 1'b0;
      m_rgt     <= 1'b0;
      s1_vld    <= 1'b0;
      s1_last   <= 1'b0;
      s2_vld    <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= out_valid && out_ready && out_last;
      if (state == IDLE && start) begin
        ksel_q <= ksel;
        relu_q <= relu_en;
        n      <= '0;
        cr     <= '0;
        cc     <= '0;
      end
      if (adv) n <= n + 1'b1;
      if (produce) begin
        if (cc == CW'(IMG_W - 1)) begin
          cc <= '0;
          cr <= cr + 1'b1;
        end else begin
          cc <= cc + 1'b1;
        end
      end
      if (!stall) begin
        w_vld     <= produce;
        w_last    <= produce && (cr == RW'(IMG_H - 1)) && (cc == CW'(IMG_W - 1));
        m_top     <= (cr == '0);
        m_bot     <= (cr == RW'(IMG_H - 1));
        m_lft     <= (cc == '0);
        m_rgt     <= (cc == CW'(IMG_W - 1));
        s1_vld    <= w_vld;
        s1_last   <= w_last;
        s2_vld    <= s1_vld;
        s2_last   <= s1_last;
        out_valid <= s2_vld;
        out_last  <= s2_vld && s2_last;
        if (s2_vld) out_data <= res;
      end
    end
  end

  // Datapath storage without reset: weights must survive reset, the rest is qualified by valids.
  always_ff @(posedge clk) begin
    if (state == IDLE && w_we) wram[w_addr] <= w_data;
    if (adv) begin
      sr[0] <= pix;
      for (int i = 1; i < SRN; i++) sr[i] <= sr[i-1];
    end
    if (!stall) begin
      for (int t = 0; t < 9; t++) p1[t] <= win[t] * wv[t];
      b1     <= SW'($signed(wram[wbase + AW'(9)]));
      s2_acc <= acc;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream_layer.sv
// Self-checking bench for conv3x3_stream_layer on a 4x4 image with two kernel banks.
// Expected results come from a direct 2-D convolution model over the whole frame.
module tb_conv3x3_stream_layer;
  localparam int DW = 20;
  localparam int FRAC = 16;
  localparam int W = 4;
  localparam int H = 4;
  localparam int NK = 2;
  localparam int KW = 1;
  localparam int AW = 5;
  localparam int NP = W*H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] ksel = '0;
  logic          relu_en = 1'b0;
  logic          w_we = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  conv3x3_stream_layer #(
    .DW(DW), .FRAC(FRAC), .IMG_W(W), .IMG_H(H), .NUM_K(NK), .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ksel(ksel), .relu_en(relu_en),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  int            n_checks = 0;
  int            n_fail = 0;
  longint        wmodel [NK*10];
  logic [DW-1:0] pix_q [NP];
  logic [DW-1:0] exp_q [NP];
  logic [DW-1:0] got_q [NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Caller sits on a falling edge; returns on the next one.
  task automatic write_w(input int a, input logic [DW-1:0] d);
    w_we = 1'b1;
    w_addr = AW'(a);
    w_data = d;
    wmodel[a] = sx(d);
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic load_bank(input int bank, input logic [DW-1:0] tapv, input logic [DW-1:0] bias);
    for (int t = 0; t < 9; t++) write_w(bank*10 + t, tapv);
    write_w(bank*10 + 9, bias);
  endtask

  task automatic fill_pix(input logic [DW-1:0] v);
    for (int i = 0; i < NP; i++) pix_q[i] = v;
  endtask

  task automatic compute_exp(input int bank, input bit relu);
    longint a;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        a = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W)
              a += sx(pix_q[(r+dr)*W + (c+dc)]) * wmodel[bank*10 + (dr+1)*3 + (dc+1)];
          end
        end
        a += wmodel[bank*10 + 9] * (longint'(1) << FRAC);
        a += longint'(1) << (FRAC - 1);
        a = a >>> FRAC;
        if (a > 524287) a = 524287;
        if (a < -524288) a = -524288;
        if (relu && a < 0) a = 0;
        exp_q[r*W + c] = a[DW-1:0];
      end
    end
  endtask

  task automatic start_frame(input int bank, input bit relu, input bit wr,
                             input int wa, input logic [DW-1:0] wd);
    start = 1'b1;
    ksel = KW'(bank);
    relu_en = relu;
    if (wr) begin
      w_we = 1'b1;
      w_addr = AW'(wa);
      w_data = wd;
      wmodel[wa] = sx(wd);
    end
    @(negedge clk);
    start = 1'b0;
    w_we = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int bank, input bit relu, input bit bp,
                           input bit gap, input bit wr, input int wa, input logic [DW-1:0] wd);
    int idx;
    int outs;
    int cyc;
    start_frame(bank, relu, wr, wa, wd);
    compute_exp(bank, relu);
    idx = 0;
    outs = 0;
    cyc = 0;
    while (outs < NP && cyc < 1000) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < NP && (!gap || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        in_data = pix_q[idx];
      end else begin
        in_valid = 1'b0;
        in_data = DW'($urandom);
      end
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        // Also covers stalled cycles: the pending result must stay on the bus.
        check({tag, "_data"}, out_data, exp_q[outs]);
        check({tag, "_last"}, out_last, outs == NP-1);
        if (out_ready) begin
          got_q[outs] = out_data;
          outs++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, outs, NP);
    check({tag, "_inputs"}, idx, NP);
    #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_no_extra"}, out_valid, 0);
    if (outs < NP) begin
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int idx;
    int cyc;
    for (int i = 0; i < NK*10; i++) wmodel[i] = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    load_bank(0, 20'h10000, 20'h00000);
    fill_pix(20'h08000);
    run_frame("half", 0, 0, 0, 0, 0, 0, '0);
    check("half_corner", got_q[0], 20'h20000);
    check("half_edge", got_q[1], 20'h30000);
    check("half_inner", got_q[5], 20'h48000);
    check("half_lastcorner", got_q[15], 20'h20000);
    run_frame("half_bp", 0, 0, 1, 1, 0, 0, '0);
    check("half_bp_inner", got_q[10], 20'h48000);

    fill_pix(20'h10000);
    run_frame("one", 0, 0, 0, 0, 0, 0, '0);
    check("one_corner", got_q[3], 20'h40000);
    check("one_edge", got_q[4], 20'h60000);
    check("one_sat", got_q[6], 20'h7FFFF);

    // Abandon a frame after 7 pixels, then verify a clean restart with the same weights.
    start_frame(0, 0, 0, 0, '0);
    idx = 0;
    cyc = 0;
    while (idx < 7 && cyc < 100) begin
      in_valid = 1'b1;
      in_data = pix_q[idx];
      out_ready = 1'b1;
      #1;
      if (in_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    check("mid_accepted", idx, 7);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame("after_rst", 0, 0, 0, 0, 0, 0, '0);
    check("after_rst_corner", got_q[0], 20'h40000);
    check("after_rst_sat", got_q[9], 20'h7FFFF);

    load_bank(1, 20'hF0000, 20'h00000);
    run_frame("neg", 1, 0, 0, 0, 0, 0, '0);
    check("neg_corner", got_q[0], 20'hC0000);
    check("neg_sat", got_q[5], 20'h80000);
    run_frame("neg_relu", 1, 1, 1, 0, 0, 0, '0);
    check("neg_relu_corner", got_q[0], 20'h00000);
    check("neg_relu_inner", got_q[5], 20'h00000);

    // Centre tap written in the same cycle as start; bank 0 tap 4 was 1.0 before.
    for (int t = 0; t < 10; t++) if (t != 4) write_w(t, 20'h00000);
    fill_pix(20'h08000);
    run_frame("rnd_hi", 0, 0, 0, 0, 1, 4, 20'h00001);
    check("rnd_hi_centre", got_q[5], 20'h00001);
    fill_pix(20'h07FFF);
    run_frame("rnd_lo", 0, 0, 0, 0, 0, 0, '0);
    check("rnd_lo_centre", got_q[5], 20'h00000);

    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 10; t++) write_w(10 + t, DW'($urandom_range(0, 20'h3FFFF) - 20'h20000));
      for (int i = 0; i < NP; i++) pix_q[i] = DW'($urandom_range(0, 20'h3FFFF) - 20'h20000);
      run_frame("rand", 1, k == 2, 1, 1, 0, 0, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
